// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its optional cache.
// The ICACHE_EN build macro selects the cached variant.
package inst_fetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ICACHE_IDX_W = 6;
    localparam int unsigned ICACHE_TAG_W = 10;

    localparam logic [XLEN-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: async lookup, single-word fill, resettable valid bits.
// Compiled only when ICACHE_EN is defined.
`ifdef ICACHE_EN
module icache
    import inst_fetch_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [ICACHE_IDX_W-1:0] lookup_idx,
    input  logic [ICACHE_TAG_W-1:0] lookup_tag,
    output logic                    lookup_hit_c,
    output logic [XLEN-1:0]         lookup_data_c,
    input  logic                    fill_en,
    input  logic [ICACHE_IDX_W-1:0] fill_idx,
    input  logic [ICACHE_TAG_W-1:0] fill_tag,
    input  logic [XLEN-1:0]         fill_data
);

    localparam int unsigned DEPTH = 1 << ICACHE_IDX_W;

    logic [DEPTH-1:0]        valid_q;
    logic [ICACHE_TAG_W-1:0] tag_q  [DEPTH];
    logic [XLEN-1:0]         data_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Payload arrays need no reset; the valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end

    assign lookup_hit_c  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_data_c = data_q[lookup_idx];

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch unit: assembles little-endian 32-bit words from a byte-wide memory port.
// Define ICACHE_EN to place a 64-entry direct-mapped cache in front of the byte port.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush_in,
    input  logic            stall_in,
    output logic            mc_req,
    output logic [XLEN-1:0] mc_addr,
    input  logic            mc_valid,
    input  logic [7:0]      mc_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            stall_req
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [23:0]     word_q, word_d;
    logic            accept;
    logic            done;
    logic            hit_c;
    logic [XLEN-1:0] hit_data_c;

    logic            mc_req_d;
    logic [XLEN-1:0] mc_addr_d;
    logic            inst_valid_d;
    logic [XLEN-1:0] inst_out_d;
    logic [XLEN-1:0] inst_pc_d;
    logic            stall_req_d;

`ifdef ICACHE_EN
    icache u_icache (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .lookup_idx    (pc_in[ICACHE_IDX_W+1:2]),
        .lookup_tag    (pc_in[ICACHE_IDX_W+ICACHE_TAG_W+1:ICACHE_IDX_W+2]),
        .lookup_hit_c  (hit_c),
        .lookup_data_c (hit_data_c),
        .fill_en       (done),
        .fill_idx      (base_q[ICACHE_IDX_W+1:2]),
        .fill_tag      (base_q[ICACHE_IDX_W+ICACHE_TAG_W+1:ICACHE_IDX_W+2]),
        .fill_data     ({mc_data, word_q})
    );
`else
    assign hit_c      = 1'b0;
    assign hit_data_c = ZeroWord;
`endif

    // State and output registers; reset outranks rdy_in and flush_in.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            base_q     <= ZeroWord;
            cnt_q      <= 2'd0;
            word_q     <= 24'd0;
            mc_req     <= 1'b0;
            mc_addr    <= ZeroWord;
            inst_valid <= 1'b0;
            inst_out   <= ZeroWord;
            inst_pc    <= ZeroWord;
            stall_req  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            mc_req     <= mc_req_d;
            mc_addr    <= mc_addr_d;
            inst_valid <= inst_valid_d;
            inst_out   <= inst_out_d;
            inst_pc    <= inst_pc_d;
            stall_req  <= stall_req_d;
        end
    end

    // Next state; a consumed VALID word behaves as IDLE so fetches run back to back.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        accept  = 1'b0;
        done    = 1'b0;
        if (flush_in) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else if (rdy_in) begin
            unique case (state_q)
                ST_IDLE:  accept = 1'b1;
                ST_FETCH: begin
                    if (mc_valid) begin
                        cnt_d = cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0:    word_d[7:0]   = mc_data;
                            2'd1:    word_d[15:8]  = mc_data;
                            2'd2:    word_d[23:16] = mc_data;
                            default: begin
                                state_d = ST_VALID;
                                done    = 1'b1;
                            end
                        endcase
                    end
                end
                ST_VALID: accept = !stall_in;
                default:  state_d = ST_IDLE;
            endcase
            if (accept) begin
                base_d  = pc_in;
                cnt_d   = 2'd0;
                state_d = hit_c ? ST_VALID : ST_FETCH;
            end
        end
    end

    // Next output values, decoded from the next state so every output leaves a flop.
    always_comb begin
        mc_req_d     = (state_d == ST_FETCH);
        stall_req_d  = (state_d == ST_FETCH);
        inst_valid_d = (state_d == ST_VALID);
        mc_addr_d    = mc_addr;
        inst_out_d   = inst_out;
        inst_pc_d    = inst_pc;
        if (state_d == ST_FETCH) begin
            mc_addr_d = base_d + XLEN'(cnt_d);
        end
        if (done) begin
            inst_out_d = {mc_data, word_q};
            inst_pc_d  = base_q;
        end else if (accept && hit_c) begin
            inst_out_d = hit_data_c;
            inst_pc_d  = pc_in;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the main fetch flow plus
// hand-written flush, ready-hold, reset and (with ICACHE_EN) cache sequences.
module tb_inst_fetch;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        flush_in;
    logic        stall_in;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_valid;
    logic [7:0]  mc_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;

    inst_fetch dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .pc_in      (pc_in),
        .flush_in   (flush_in),
        .stall_in   (stall_in),
        .mc_req     (mc_req),
        .mc_addr    (mc_addr),
        .mc_valid   (mc_valid),
        .mc_data    (mc_data),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .stall_req  (stall_req)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst, rdy, flush, stall;
        logic [31:0] pc;
        logic        mv;
        logic [7:0]  md;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic r, rd, fl, st, input logic [31:0] pc,
                                input logic mv, input logic [7:0] md,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_inst,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = r; v.rdy = rd; v.flush = fl; v.stall = st; v.pc = pc;
        v.mv = mv; v.md = md; v.e_req = e_req; v.e_addr = e_addr;
        v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive(input logic r, rd, fl, st, input logic [31:0] pc,
                         input logic mv, input logic [7:0] md);
        rst_in = r; rdy_in = rd; flush_in = fl; stall_in = st;
        pc_in = pc; mc_valid = mv; mc_data = md;
    endtask

    // Address is only meaningful while requesting, the word only while valid;
    // 'full' forces every field to be compared (used for the all-zero reset state).
    task automatic expect_out(input string name, input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_pc, input logic full);
        logic bad;
        bad = (mc_req !== e_req) || (stall_req !== e_req) || (inst_valid !== e_iv);
        if (e_req || full) bad = bad || (mc_addr !== e_addr);
        if (e_iv || full)  bad = bad || (inst_out !== e_inst) || (inst_pc !== e_pc);
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: got req=%0b stall_req=%0b addr=%h iv=%0b inst=%h pc=%h; want req=%0b addr=%h iv=%0b inst=%h pc=%h",
                     name, mc_req, stall_req, mc_addr, inst_valid, inst_out, inst_pc,
                     e_req, e_addr, e_iv, e_inst, e_pc);
        end
    endtask

    task automatic step(input string name, input logic r, rd, fl, st, input logic [31:0] pc,
                        input logic mv, input logic [7:0] md,
                        input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                        input logic [31:0] e_inst, input logic [31:0] e_pc, input logic full);
        drive(r, rd, fl, st, pc, mv, md);
        @(posedge clk_in);
        #1;
        expect_out(name, e_req, e_addr, e_iv, e_inst, e_pc, full);
    endtask

    // Feed four bytes of 'word' from a fresh FETCH at 'base', one per cycle.
    task automatic feed_word(input string name, input logic [31:0] base, input logic [31:0] word);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = word[8*k +: 8];
            if (k < 3)
                step($sformatf("%s_b%0d", name, k), 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, b,
                     1'b1, base + 32'(k + 1), 1'b0, 32'h0, 32'h0, 1'b0);
            else
                step($sformatf("%s_done", name), 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, b,
                     1'b0, 32'h0, 1'b1, word, base, 1'b0);
        end
    endtask

    initial begin
        // rst rdy fl st pc mv md | req addr iv inst pc
        vt[0]  = mk(1, 1, 0, 0, 32'h100, 0, 8'h00, 0, 32'h0,        0, 32'h0,        32'h0);
        vt[1]  = mk(0, 1, 0, 0, 32'h100, 0, 8'h00, 1, 32'h100,      0, 32'h0,        32'h0);
        vt[2]  = mk(0, 1, 0, 0, 32'h100, 1, 8'h93, 1, 32'h101,      0, 32'h0,        32'h0);
        vt[3]  = mk(0, 1, 0, 0, 32'h100, 1, 8'h00, 1, 32'h102,      0, 32'h0,        32'h0);
        vt[4]  = mk(0, 1, 0, 0, 32'h100, 1, 8'hA0, 1, 32'h103,      0, 32'h0,        32'h0);
        vt[5]  = mk(0, 1, 0, 1, 32'h104, 1, 8'h00, 0, 32'h0,        1, 32'h00A00093, 32'h100);
        vt[6]  = mk(0, 1, 0, 1, 32'h104, 1, 8'hFF, 0, 32'h0,        1, 32'h00A00093, 32'h100);
        vt[7]  = mk(0, 1, 0, 1, 32'h104, 0, 8'h00, 0, 32'h0,        1, 32'h00A00093, 32'h100);
        vt[8]  = mk(0, 1, 0, 1, 32'h104, 0, 8'h00, 0, 32'h0,        1, 32'h00A00093, 32'h100);
        vt[9]  = mk(0, 1, 0, 0, 32'h104, 0, 8'h00, 1, 32'h104,      0, 32'h0,        32'h0);
        vt[10] = mk(0, 1, 0, 0, 32'h104, 0, 8'h00, 1, 32'h104,      0, 32'h0,        32'h0);
        vt[11] = mk(0, 1, 0, 0, 32'h104, 1, 8'h78, 1, 32'h105,      0, 32'h0,        32'h0);
        vt[12] = mk(0, 1, 0, 0, 32'h104, 1, 8'h56, 1, 32'h106,      0, 32'h0,        32'h0);
        vt[13] = mk(0, 1, 0, 0, 32'h104, 1, 8'h34, 1, 32'h107,      0, 32'h0,        32'h0);
        vt[14] = mk(0, 1, 0, 0, 32'hFFFFFFFE, 1, 8'h12, 0, 32'h0,   1, 32'h12345678, 32'h104);
        vt[15] = mk(0, 1, 0, 0, 32'hFFFFFFFE, 0, 8'h00, 1, 32'hFFFFFFFE, 0, 32'h0,   32'h0);
        vt[16] = mk(0, 1, 0, 0, 32'hFFFFFFFE, 1, 8'h11, 1, 32'hFFFFFFFF, 0, 32'h0,   32'h0);
        vt[17] = mk(0, 1, 0, 0, 32'hFFFFFFFE, 1, 8'h22, 1, 32'h00000000, 0, 32'h0,   32'h0);
        vt[18] = mk(0, 1, 0, 0, 32'hFFFFFFFE, 1, 8'h33, 1, 32'h00000001, 0, 32'h0,   32'h0);
        vt[19] = mk(0, 1, 0, 1, 32'hFFFFFFFE, 1, 8'h44, 0, 32'h0,   1, 32'h44332211, 32'hFFFFFFFE);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vt[i].rst, vt[i].rdy, vt[i].flush, vt[i].stall,
                 vt[i].pc, vt[i].mv, vt[i].md, vt[i].e_req, vt[i].e_addr, vt[i].e_iv,
                 vt[i].e_inst, vt[i].e_pc, vt[i].rst);
        end

        // Flush on the third byte: byte dropped, request gone, clean refetch at 0x200.
        step("fl_acc",  0, 1, 0, 0, 32'h300, 0, 8'h00, 1, 32'h300, 0, 32'h0, 32'h0, 0);
        step("fl_b0",   0, 1, 0, 0, 32'h300, 1, 8'hAA, 1, 32'h301, 0, 32'h0, 32'h0, 0);
        step("fl_b1",   0, 1, 0, 0, 32'h300, 1, 8'hBB, 1, 32'h302, 0, 32'h0, 32'h0, 0);
        step("fl_hit",  0, 1, 1, 0, 32'h200, 1, 8'hEE, 0, 32'h0,   0, 32'h0, 32'h0, 0);
        step("fl_new",  0, 1, 0, 0, 32'h200, 0, 8'h00, 1, 32'h200, 0, 32'h0, 32'h0, 0);
        feed_word("fl_word", 32'h200, 32'hDEADBEEF);

        // rdy_in low for five cycles mid-fetch: everything frozen, stray bytes ignored.
        step("rdy_acc", 0, 1, 0, 0, 32'h400, 0, 8'h00, 1, 32'h400, 0, 32'h0, 32'h0, 0);
        step("rdy_b0",  0, 1, 0, 0, 32'h400, 1, 8'h01, 1, 32'h401, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 5; i++)
            step($sformatf("rdy_hold%0d", i), 0, 0, 0, 0, 32'h999, 1, 8'h99,
                 1, 32'h401, 0, 32'h0, 32'h0, 0);
        step("rdy_b1",  0, 1, 0, 1, 32'h0, 1, 8'h02, 1, 32'h402, 0, 32'h0, 32'h0, 0);
        step("rdy_b2",  0, 1, 0, 1, 32'h0, 1, 8'h03, 1, 32'h403, 0, 32'h0, 32'h0, 0);
        step("rdy_end", 0, 1, 0, 1, 32'h0, 1, 8'h04, 0, 32'h0, 1, 32'h04030201, 32'h400, 0);

        // Reset on the third byte, with flush and rdy_in low alongside: all outputs zero.
        step("rs_acc",  0, 1, 0, 0, 32'h500, 0, 8'h00, 1, 32'h500, 0, 32'h0, 32'h0, 0);
        step("rs_b0",   0, 1, 0, 0, 32'h500, 1, 8'h0A, 1, 32'h501, 0, 32'h0, 32'h0, 0);
        step("rs_b1",   0, 1, 0, 0, 32'h500, 1, 8'h0B, 1, 32'h502, 0, 32'h0, 32'h0, 0);
        step("rs_hit",  1, 0, 1, 0, 32'h600, 1, 8'h0C, 0, 32'h0,   0, 32'h0, 32'h0, 1);
        step("rs_idle0", 0, 0, 0, 0, 32'h600, 1, 8'h0D, 0, 32'h0,  0, 32'h0, 32'h0, 1);
        step("rs_idle1", 0, 0, 0, 0, 32'h600, 1, 8'h0D, 0, 32'h0,  0, 32'h0, 32'h0, 1);
        step("rs_new",  0, 1, 0, 0, 32'h600, 0, 8'h00, 1, 32'h600, 0, 32'h0, 32'h0, 0);
        feed_word("rs_word", 32'h600, 32'h76543210);

`ifdef ICACHE_EN
        // Cache: miss then hit at 0x100, conflicting tag evicts it, refill, rehit.
        step("c_miss0", 0, 1, 0, 0, 32'h100, 0, 8'h00, 1, 32'h100, 0, 32'h0, 32'h0, 0);
        feed_word("c_fill0", 32'h100, 32'h00A00093);
        step("c_hit0",  0, 1, 0, 0, 32'h100, 0, 8'h00, 0, 32'h0, 1, 32'h00A00093, 32'h100, 0);
        step("c_miss1", 0, 1, 0, 0, 32'h10100, 0, 8'h00, 1, 32'h10100, 0, 32'h0, 32'h0, 0);
        feed_word("c_fill1", 32'h10100, 32'hCAFEF00D);
        step("c_hit1",  0, 1, 0, 0, 32'h10100, 0, 8'h00, 0, 32'h0, 1, 32'hCAFEF00D, 32'h10100, 0);
        step("c_evict", 0, 1, 0, 0, 32'h100, 0, 8'h00, 1, 32'h100, 0, 32'h0, 32'h0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_in, rst_in.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 rdy_in  input  1  global ready; when low, all state and outputs hold.
REQ-005 pc_in  input  32  fetch address from the PC register.
REQ-006 flush_in  input  1  taken jump; abort the current fetch.
REQ-007 stall_in  input  1  downstream (IF/ID) cannot accept; hold output.
REQ-008 mc_req  output  1  byte request to the memory controller, held until the 4th byte arrives.
REQ-009 mc_addr  output  32  byte address requested: base + byte_cnt.
REQ-010 mc_valid  input  1  one returned byte valid this cycle.
REQ-011 mc_data  input  8  returned byte.
REQ-012 inst_valid  output  1  inst_out and inst_pc are valid.
REQ-013 inst_out  output  32  fetched instruction word, little-endian.
REQ-014 inst_pc  output  32  address of inst_out.
REQ-015 stall_req  output  1  fetch busy; pipeline must not advance the PC.

Function
REQ-016 SHALL implement the FSM IDLE, FETCH and VALID with a 2-bit byte counter byte_cnt.
REQ-017 IDLE with rdy_in and no flush: SHALL latch pc_in into base and clear byte_cnt; a cache miss or no cache goes to FETCH, a cache hit goes to VALID.
REQ-018 FETCH: SHALL drive mc_req=1 and mc_addr=base+byte_cnt.
REQ-019 FETCH, on each mc_valid: SHALL store mc_data in byte lane byte_cnt and increment byte_cnt.
REQ-020 On the 4th mc_valid (byte_cnt=3): SHALL go to VALID; inst_valid=1 from the next cycle; mc_req=0 from the next cycle.
REQ-021 VALID: SHALL hold inst_valid, inst_out and inst_pc=base while stall_in=1.
REQ-022 VALID with stall_in=0: the word is consumed and SHALL behave as IDLE in the same cycle, accepting pc_in, giving back-to-back fetches.
REQ-023 stall_req SHALL be 1 exactly when the state is FETCH.
REQ-024 flush_in SHALL have priority over all other inputs: from any state go to IDLE, inst_valid=0 and mc_req=0 next cycle, and discard any mc_valid byte in the flush cycle.
REQ-025 mc_valid outside FETCH SHALL be ignored.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32; base=0xFFFFFFFE wraps mc_addr to 0x00000000 and 0x00000001.

Reset
REQ-027 rst_in SHALL force state=IDLE, byte_cnt=0 and base=0, and all outputs to 0, with priority over rdy_in and flush_in.
REQ-028 rst_in mid-FETCH SHALL discard partial bytes, with no residual mc_req.

Configuration
REQ-029 Macro ICACHE_EN SHALL compile in a 64-entry direct-mapped instruction cache: index pc[7:2], tag pc[17:8], one valid bit per entry.
REQ-030 With ICACHE_EN, a hit in IDLE SHALL go directly to VALID with no mc_req; a miss SHALL fill the entry on the 4th byte; reset SHALL clear all valid bits.
REQ-031 Without ICACHE_EN, every fetch SHALL go through FETCH; cache storage SHALL not exist.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, ZeroWord, ICACHE_IDX_W=6 and ICACHE_TAG_W=10.
REQ-033 The cache SHALL be a sub-module icache (lookup and fill ports), instantiated only under ICACHE_EN.

Verification
REQ-034 pc_in=0x100, mem word 0x00A00093, one byte per cycle -> mc_addr 0x100..0x103; inst_valid with inst_out=0x00A00093 and inst_pc=0x100; stall_req high 4 cycles.
REQ-035 stall_in=1 for 3 cycles in VALID -> outputs stable; next pc_in=0x104 accepted the cycle stall_in falls.
REQ-036 flush_in after 2 bytes, same cycle as mc_valid -> byte dropped; inst_valid=0; mc_req=0 next cycle; new pc_in=0x200 fetched cleanly.
REQ-037 rdy_in=0 mid-FETCH for 5 cycles -> byte_cnt and outputs frozen; completion correct after resume.
REQ-038 ICACHE_EN: fetch 0x100 twice -> second reaches VALID one cycle after accept with no mc_req; then fetch 0x10100 (same index, new tag) -> miss and refill.
REQ-039 rst_in during byte 3 -> all outputs 0 next cycle; no mc_req until the next fetch.
